// File: rtl/mips_alu_exec_unit.sv
// mips_alu_exec_unit: registered EX-stage ALU; latency 1, MULT WIDTH+1; result held while out_valid & !out_ready.
// in_ready low while a result is stalled or a MULT iterates; ALU_MULT_EN builds MULT/MFHI/MFLO and HI/LO.
module mips_alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] HILO_RST = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [5:0]               funct,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [3:0]               alu_ctrl,
  output logic                     zero,
  output logic                     ovf,
  output logic                     illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_XOR = 4'b0011;
  localparam logic [3:0] C_SLL = 4'b1000;
  localparam logic [3:0] C_SRL = 4'b1001;
  localparam logic [3:0] C_SRA = 4'b1010;
`ifdef ALU_MULT_EN
  localparam logic [3:0] C_MULT = 4'b1101;
  localparam logic [3:0] C_MFHI = 4'b1110;
  localparam logic [3:0] C_MFLO = 4'b1111;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd1
`ifdef ALU_MULT_EN
    , S_MUL = 2'd2
`endif
  } state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic [3:0]        dec_ctrl;
  logic              dec_ill;
  logic              dec_mult;
  logic [WIDTH-1:0]  sum, diff, exe_res;
  logic              exe_ovf;

`ifdef ALU_MULT_EN
  logic [WIDTH-1:0]   hi, lo, mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [SHAMT_W-1:0] cnt;
`else
  logic unused_hilo_rst;
  assign unused_hilo_rst = ^HILO_RST;
`endif

  assign in_ready = (state == S_IDLE) || ((state == S_RESP) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_ctrl = C_AND;
    dec_ill  = 1'b0;
    dec_mult = 1'b0;
    case (alu_op)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      2'b11: dec_ctrl = C_SLT;
      default: begin
        case (funct)
          6'b100000: dec_ctrl = C_ADD;
          6'b100010: dec_ctrl = C_SUB;
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b101010: dec_ctrl = C_SLT;
          6'b100111: dec_ctrl = C_NOR;
          6'b100110: dec_ctrl = C_XOR;
          6'b000000: dec_ctrl = C_SLL;
          6'b000010: dec_ctrl = C_SRL;
          6'b000011: dec_ctrl = C_SRA;
`ifdef ALU_MULT_EN
          6'b011000: begin
            dec_ctrl = C_MULT;
            dec_mult = 1'b1;
          end
          6'b010000: dec_ctrl = C_MFHI;
          6'b010010: dec_ctrl = C_MFLO;
`endif
          default:   dec_ill  = 1'b1;
        endcase
      end
    endcase
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    exe_res = '0;
    exe_ovf = 1'b0;
    // Illegal ops keep the zero result that was defaulted above.
    if (!dec_ill) begin
      case (dec_ctrl)
        C_ADD: begin
          exe_res = sum;
          exe_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        end
        C_SUB: begin
          exe_res = diff;
          exe_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        end
        C_AND: exe_res = op_a & op_b;
        C_OR:  exe_res = op_a | op_b;
        C_SLT: exe_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        C_NOR: exe_res = ~(op_a | op_b);
        C_XOR: exe_res = op_a ^ op_b;
        C_SLL: exe_res = op_b << shamt;
        C_SRL: exe_res = op_b >> shamt;
        C_SRA: exe_res = $unsigned($signed(op_b) >>> shamt);
`ifdef ALU_MULT_EN
        C_MFHI: exe_res = hi;
        C_MFLO: exe_res = lo;
`endif
        default: exe_res = '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_RESP;
`ifdef ALU_MULT_EN
        if (accept && dec_mult) state_nxt = S_MUL;
`endif
      end
      S_RESP: begin
        if (accept) state_nxt = S_RESP;
        else if (out_ready) state_nxt = S_IDLE;
`ifdef ALU_MULT_EN
        if (accept && dec_mult) state_nxt = S_MUL;
`endif
      end
`ifdef ALU_MULT_EN
      S_MUL: if (cnt == '0) state_nxt = S_RESP;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      alu_ctrl  <= 4'b0000;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (accept && !dec_mult) begin
        out_valid <= 1'b1;
        result    <= exe_res;
        alu_ctrl  <= dec_ctrl;
        zero      <= (exe_res == '0);
        ovf       <= exe_ovf;
        illegal   <= dec_ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef ALU_MULT_EN
      if ((state == S_MUL) && (cnt == '0)) begin
        out_valid <= 1'b1;
        result    <= acc_nxt[WIDTH-1:0];
        alu_ctrl  <= C_MULT;
        zero      <= (acc_nxt[WIDTH-1:0] == '0);
        ovf       <= 1'b0;
        illegal   <= 1'b0;
      end
`endif
    end
  end

`ifdef ALU_MULT_EN
  // Multiplier bits consumed MSB first, so the partial product shifts left each step.
  assign acc_nxt = (acc << 1) + (mplier[cnt] ? {{WIDTH{1'b0}}, mcand} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= HILO_RST;
      lo     <= HILO_RST;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && dec_mult) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      cnt    <= SHAMT_W'(WIDTH-1);
    end else if (state == S_MUL) begin
      if (cnt == '0) begin
        hi <= acc_nxt[2*WIDTH-1:WIDTH];
        lo <= acc_nxt[WIDTH-1:0];
      end else begin
        acc <= acc_nxt;
        cnt <= cnt - 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_alu_exec_unit.sv
// Randomized scoreboard bench for mips_alu_exec_unit; expectations come from an arithmetic reference model.
// Honours ALU_MULT_EN the same way as the design (MULT/MFHI/MFLO legal only when defined).
module tb_mips_alu_exec_unit;

  localparam logic [31:0] HRST = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] op_a, op_b, result;
  logic [3:0]  alu_ctrl;
  logic        zero, ovf, illegal;

  mips_alu_exec_unit #(.WIDTH(32), .HILO_RST(HRST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .alu_ctrl(alu_ctrl), .zero(zero), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic        z;
    logic        o;
    logic        il;
  } exp_t;

  exp_t        sbq[$];
  int          pop_cyc[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] m_hi = HRST;
  logic [31:0] m_lo = HRST;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: each op evaluated as plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    logic [5:0]      k;
    longint          s;
    longint unsigned p;
    int              sb;
    e = '0;
    k = (op == 2'b00) ? 6'h20 : (op == 2'b01) ? 6'h22 : (op == 2'b11) ? 6'h2A : f;
    case (k)
      6'h20: begin
        s = longint'(int'(a)) + longint'(int'(b));
        e.res = s[31:0]; e.ctrl = 4'b0010;
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h22: begin
        s = longint'(int'(a)) - longint'(int'(b));
        e.res = s[31:0]; e.ctrl = 4'b0110;
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h24: begin e.res = a & b;    e.ctrl = 4'b0000; end
      6'h25: begin e.res = a | b;    e.ctrl = 4'b0001; end
      6'h2A: begin e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; e.ctrl = 4'b0111; end
      6'h27: begin e.res = ~(a | b); e.ctrl = 4'b1100; end
      6'h26: begin e.res = a ^ b;    e.ctrl = 4'b0011; end
      6'h00: begin e.res = b << sh;  e.ctrl = 4'b1000; end
      6'h02: begin e.res = b >> sh;  e.ctrl = 4'b1001; end
      6'h03: begin sb = int'(b); sb = sb >>> sh; e.res = sb; e.ctrl = 4'b1010; end
`ifdef ALU_MULT_EN
      6'h18: begin
        p = longint'({32'b0, a}) * longint'({32'b0, b});
        m_hi = p[63:32]; m_lo = p[31:0];
        e.res = p[31:0]; e.ctrl = 4'b1101;
      end
      6'h10: begin e.res = m_hi; e.ctrl = 4'b1110; end
      6'h12: begin e.res = m_lo; e.ctrl = 4'b1111; end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic push_exp();
    sbq.push_back(model(alu_op, funct, shamt, op_a, op_b));
  endtask

  // Monitor: every output handshake is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got result %h ctrl %b with empty scoreboard", result, alu_ctrl);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("response{res,ctrl,zero,ovf,illegal}", {25'b0, result, alu_ctrl, zero, ovf, illegal}, {25'b0, e});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the op was accepted.
  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, output int acyc);
    in_valid = 1'b1; alu_op = op; funct = f; shamt = sh; op_a = a; op_b = b;
    acyc = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acyc = cyc;
        push_exp();
        break;
      end
      @(posedge clk); #1;
    end
    if (acyc < 0) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: in_ready never rose, got 0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    int t;
    t = 0;
    while (pop_cyc.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("output_count", 64'(pop_cyc.size() >= n), 64'd1);
  endtask

  logic [5:0]  fpool [15] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h26, 6'h00,
                              6'h02, 6'h03, 6'h18, 6'h10, 6'h12, 6'h3F, 6'h01};
  logic [31:0] vpool [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h5};

  function automatic logic [31:0] rand_opnd();
    if ($urandom_range(0, 2) == 0) return vpool[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  int a0, a1, first_acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct = 6'h0; shamt = 5'd0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result",    64'(result),    64'd0);
    chk("reset_alu_ctrl",  64'(alu_ctrl),  64'd0);
    chk("reset_zero",      64'(zero),      64'd0);
    chk("reset_ovf",       64'(ovf),       64'd0);
    chk("reset_illegal",   64'(illegal),   64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Overflowing add with the result stalled: outputs must hold and in_ready must drop.
    out_ready = 1'b0;
    issue(2'b10, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'h1, a0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_result",    64'(result),    64'h8000_0000);
      chk("hold_ovf",       64'(ovf),       64'd1);
      chk("hold_zero",      64'(zero),      64'd0);
      chk("hold_alu_ctrl",  64'(alu_ctrl),  64'b0010);
      chk("hold_in_ready",  64'(in_ready),  64'd0);
    end
    @(posedge clk); #1;
    pop_cyc.delete();
    out_ready = 1'b1;
    wait_pops(1);

    pop_cyc.delete();
    issue(2'b01, 6'h3F, 5'd0, 32'h5, 32'h5, a0);
    wait_pops(1);
    chk("latency_single", 64'(pop_cyc[0] - a0), 64'd1);
    issue(2'b10, 6'b000011, 5'd4, 32'h0, 32'hF000_0000, a0);
    issue(2'b10, 6'b111111, 5'd0, 32'h1234, 32'h5678, a0);
    issue(2'b10, 6'b011000, 5'd0, 32'h3, 32'h4, a0);
    issue(2'b11, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h1, a0);
    wait_pops(5);

    // Four back-to-back ops with out_ready high: one result per cycle.
    pop_cyc.delete();
    first_acc = -1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; alu_op = 2'b10; funct = fpool[i + 2]; shamt = 5'(i);
      op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      if (in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        push_exp();
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_pops(4);
    for (int i = 0; i < 4; i++)
      chk("b2b_output_cycle", 64'(pop_cyc[i]), 64'(first_acc + 1 + i));

`ifdef ALU_MULT_EN
    pop_cyc.delete();
    issue(2'b10, 6'b011000, 5'd0, 32'h0001_0000, 32'h0001_0000, a1);
    wait_pops(1);
    chk("latency_mult", 64'(pop_cyc[0] - a1), 64'd33);
    issue(2'b10, 6'b010000, 5'd0, 32'h0, 32'h0, a0);
    issue(2'b10, 6'b010010, 5'd0, 32'h0, 32'h0, a0);
    wait_pops(3);

    // Reset in the middle of a multiply: it is dropped and HI/LO return to HILO_RST.
    issue(2'b10, 6'b011000, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, a0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_mul_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #2;
    chk("mid_mul_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_mul_rst_result",    64'(result),    64'd0);
    sbq.delete();
    m_hi = HRST; m_lo = HRST;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    pop_cyc.delete();
    issue(2'b10, 6'b010000, 5'd0, 32'h0, 32'h0, a0);
    issue(2'b10, 6'b010010, 5'd0, 32'h0, 32'h0, a0);
    wait_pops(2);
`else
    // Reset while a result is stalled at the output.
    out_ready = 1'b0;
    issue(2'b00, 6'h0, 5'd0, 32'h11, 32'h22, a0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("stall_rst_out_valid", 64'(out_valid), 64'd0);
    chk("stall_rst_result",    64'(result),    64'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      alu_op    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) alu_op = 2'b10;
      funct     = fpool[$urandom_range(0, 14)];
      shamt     = 5'($urandom_range(0, 31));
      op_a      = rand_opnd();
      op_b      = rand_opnd();
      @(negedge clk);
      if (in_valid && in_ready) push_exp();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && sbq.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
